x4xx_samples_to_gpio_mux: RTL and testbench
===========================================

# x4xx_samples_to_gpio_mux

Drives NUM_GPIO output lines from selected bits of the TX sample stream. Each line has its own channel/sample/bit selection and output mode (level, stretched pulse, toggle), plus a shared strobe-starvation timeout. It sits in the x4xx radio clock domain between the radio TX datapath and the front-panel GPIO output mux. It generalises the single-line, channel-0, bit-0 sample-to-GPIO path.

## Interface
Parameters:
- NUM_CHANNELS, 4: number of radio channels in tx_data/tx_stb (max 16)
- RADIO_SPC, 1: samples per radio_clk cycle per channel (max 16)
- NUM_GPIO, 4: number of output lines (min 1)
- TIMEOUT_W, 16: width of the shared timeout counter

Ports:
- radio_clk  in  1  radio clock; the only clock
- radio_rst_n  in  1  reset, asynchronous assert, active-low
- tx_data  in  32*RADIO_SPC*NUM_CHANNELS  TX samples; channel c, sample s occupies bits [32*(c*RADIO_SPC+s) +: 32]
- tx_stb  in  NUM_CHANNELS  per-channel sample valid
- cfg_wr_en  in  1  one-cycle config write strobe
- cfg_addr  in  $clog2(NUM_GPIO+1)  0..NUM_GPIO-1 selects a line register; NUM_GPIO selects the timeout register
- cfg_wdata  in  32  write data
- gpio_out  out  NUM_GPIO  registered GPIO drive

## Operation
- Line register fields:
  - [4:0] bit_sel
  - [8:5] samp_sel
  - [12:9] chan_sel
  - [13] idle_val
  - [15:14] mode: 0 level, 1 pulse, 2 toggle, 3 treated as level
  - [16] enable
  - [31:24] pulse_len
- Timeout register: [TIMEOUT_W-1:0] timeout, where 0 disables the timeout. Writes to other addresses are ignored.
- Per line, the selected bit is b = tx_data[32*(chan_sel*RADIO_SPC+samp_sel)+bit_sel]. It is sampled only on cycles with tx_stb[chan_sel]=1.
- Line forced to idle_val, with no state updates, when either:
  - enable=0, or
  - chan_sel >= NUM_CHANNELS, or
  - samp_sel >= RADIO_SPC
- Each line keeps a prev_bit register, updated on every qualifying strobe. A rising edge is prev_bit=0 and b=1 on a qualifying strobe.
- Level mode: output follows b on each strobe and holds between strobes.
- Pulse mode: a rising edge drives the output to ~idle_val for pulse_len+1 cycles, counted by a per-line 8-bit down-counter, then returns to idle_val. A new edge during a pulse reloads the counter, so the pulse is extended rather than doubled.
- Toggle mode: output state inverts on each rising edge. It starts at idle_val.
- Timeout, level mode only:
  - Each line has a starvation counter, cleared on each qualifying strobe.
  - When it reaches timeout, the output returns to idle_val and the counter saturates.
  - The next strobe resumes normal level behaviour.
- Config write to line n:
  - takes effect on the cycle after cfg_wr_en;
  - clears prev_bit, pulse counter and starvation counter;
  - sets output to the new idle_val.
  - Other lines are unaffected.
- Timeout register write: new value used from the next cycle. Running counters are not cleared.
- Write and strobe on the same cycle for the same line: the write wins and the strobe is discarded for that line.

## Timing
- Reset: gpio_out=0, all line registers 0 (disabled, idle 0), timeout=0, all internal state 0. Async assert, synchronous deassert use.
- Strobe to gpio_out latency: 1 cycle in every mode. Output is registered with no combinational path from inputs.
- Pulse from an edge at cycle t: gpio_out is ~idle_val for cycles t+1 .. t+1+pulse_len.
- Timeout: last strobe at cycle t with timeout=T gives gpio_out=idle_val from cycle t+T+1.
- Config write at cycle t: gpio_out reflects the new config from t+1.

## Test plan
- Reset, then a write to line 0 with enable=1, mode 0, chan 0, samp 0, bit 0. Strobed tx_data bit0 sequence 1,0,1 gives gpio_out[0] = 1,0,1 each one cycle after its strobe; gpio_out[3:1]=0 throughout.
- RADIO_SPC=2, line 1 selecting chan 3, samp 1, bit 17. Toggling only that bit with tx_stb[3] gives gpio_out[1] tracking it. Strobes on channels 0..2 cause no change.
- Pulse mode with pulse_len=4, single rising edge: high for exactly 5 cycles. A second edge 2 cycles into the pulse gives high for 2+5 cycles total.
- Toggle mode with idle_val=1 and bit pattern 0,1,1,0,1: output is 1 until the first edge, then 0, then 1 after the second edge.
- timeout=10, level mode, bit=1 strobed once then no strobes: gpio_out returns to idle 0 exactly 11 cycles after the strobe. The next strobe with b=1 gives 1 again.
- Covers both boundary conditions:
  - chan_sel=15 with NUM_CHANNELS=4 holds idle_val.
  - A same-cycle write and strobe applies the write and discards the strobe.
- Covers both reset cases:
  - radio_rst_n asserted mid-pulse gives gpio_out=0 immediately (async).
  - After release, all lines stay at 0 until reconfigured.

Source files
------------

// File: rtl/x4xx_samples_to_gpio_mux.sv
// x4xx_samples_to_gpio_mux: drives NUM_GPIO lines from selected TX sample bits.
// Ports: radio_clk/radio_rst_n, tx_data/tx_stb (TX stream), cfg_* (register writes), gpio_out.
module x4xx_samples_to_gpio_mux #(
  parameter int NUM_CHANNELS = 4,
  parameter int RADIO_SPC    = 1,
  parameter int NUM_GPIO     = 4,
  parameter int TIMEOUT_W    = 16
) (
  input  logic                                  radio_clk,
  input  logic                                  radio_rst_n,
  input  logic [32*RADIO_SPC*NUM_CHANNELS-1:0]  tx_data,
  input  logic [NUM_CHANNELS-1:0]               tx_stb,
  input  logic                                  cfg_wr_en,
  input  logic [$clog2(NUM_GPIO+1)-1:0]         cfg_addr,
  input  logic [31:0]                           cfg_wdata,
  output logic [NUM_GPIO-1:0]                   gpio_out
);

  localparam int AW = $clog2(NUM_GPIO+1);

  typedef struct packed {
    logic                 en;
    logic [1:0]           mode;
    logic                 idle;
    logic [3:0]           chan;
    logic [3:0]           samp;
    logic [4:0]           bsel;
    logic [7:0]           plen;
    logic                 prev;
    logic [7:0]           cnt;
    logic [TIMEOUT_W-1:0] starve;
    logic                 out;
  } line_t;

  line_t                line_q [NUM_GPIO];
  line_t                line_d [NUM_GPIO];
  logic [TIMEOUT_W-1:0] timeout_q;
  logic [TIMEOUT_W-1:0] timeout_d;

  logic                 unused_wdata;
  assign unused_wdata = ^cfg_wdata;

  logic                 hit;
  logic                 stb;
  logic                 b;
  logic                 rise;
  logic [31:0]          word;
  logic [TIMEOUT_W-1:0] inc;

  always_comb begin
    timeout_d = timeout_q;
    hit  = 1'b0;
    stb  = 1'b0;
    b    = 1'b0;
    rise = 1'b0;
    word = '0;
    inc  = '0;
    if (cfg_wr_en && cfg_addr == AW'(NUM_GPIO))
      timeout_d = cfg_wdata[TIMEOUT_W-1:0];
    for (int i = 0; i < NUM_GPIO; i++) begin
      line_d[i] = line_q[i];
      hit  = 1'b0;
      stb  = 1'b0;
      word = '0;
      // Out-of-range chan/samp selections never match, leaving hit low.
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        for (int s = 0; s < RADIO_SPC; s++) begin
          if (line_q[i].chan == 4'(c) && line_q[i].samp == 4'(s)) begin
            hit  = 1'b1;
            stb  = tx_stb[c];
            word = tx_data[32*(c*RADIO_SPC+s) +: 32];
          end
        end
      end
      b    = word[line_q[i].bsel];
      rise = stb & b & ~line_q[i].prev;
      inc  = line_q[i].starve + TIMEOUT_W'(1);
      if (cfg_wr_en && cfg_addr == AW'(i)) begin
        line_d[i]      = '0;
        line_d[i].bsel = cfg_wdata[4:0];
        line_d[i].samp = cfg_wdata[8:5];
        line_d[i].chan = cfg_wdata[12:9];
        line_d[i].idle = cfg_wdata[13];
        line_d[i].mode = cfg_wdata[15:14];
        line_d[i].en   = cfg_wdata[16];
        line_d[i].plen = cfg_wdata[31:24];
        line_d[i].out  = cfg_wdata[13];
      end else if (!line_q[i].en || !hit) begin
        line_d[i].out = line_q[i].idle;
      end else begin
        case (line_q[i].mode)
          2'd1: begin
            if (stb) line_d[i].prev = b;
            if (rise) begin
              line_d[i].cnt = line_q[i].plen;
              line_d[i].out = ~line_q[i].idle;
            end else if (line_q[i].cnt != 8'd0) begin
              line_d[i].cnt = line_q[i].cnt - 8'd1;
              line_d[i].out = ~line_q[i].idle;
            end else begin
              line_d[i].out = line_q[i].idle;
            end
          end
          2'd2: begin
            if (stb) line_d[i].prev = b;
            if (rise) line_d[i].out = ~line_q[i].out;
          end
          default: begin
            if (stb) begin
              line_d[i].out    = b;
              line_d[i].prev   = b;
              line_d[i].starve = '0;
            end else if (timeout_q != '0) begin
              // Saturate once the limit is hit; output stays idle.
              if (line_q[i].starve >= timeout_q) begin
                line_d[i].out = line_q[i].idle;
              end else begin
                line_d[i].starve = inc;
                if (inc == timeout_q) line_d[i].out = line_q[i].idle;
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge radio_clk or negedge radio_rst_n) begin
    if (!radio_rst_n) begin
      timeout_q <= '0;
      for (int i = 0; i < NUM_GPIO; i++) line_q[i] <= '0;
    end else begin
      timeout_q <= timeout_d;
      for (int i = 0; i < NUM_GPIO; i++) line_q[i] <= line_d[i];
    end
  end

  always_comb begin
    gpio_out = '0;
    for (int i = 0; i < NUM_GPIO; i++) gpio_out[i] = line_q[i].out;
  end

endmodule

// File: tb/tb_x4xx_samples_to_gpio_mux.sv
// tb_x4xx_samples_to_gpio_mux: directed checks of the sample-to-GPIO mux.
// Drives TX strobes and config writes, checks gpio_out against hand values.
module tb_x4xx_samples_to_gpio_mux;

  logic         clk;
  logic         rst_n;
  logic [255:0] tx_data;
  logic [3:0]   tx_stb;
  logic         cfg_wr_en;
  logic [2:0]   cfg_addr;
  logic [31:0]  cfg_wdata;
  logic [3:0]   gpio_out;

  int checks = 0;
  int errors = 0;

  x4xx_samples_to_gpio_mux #(
    .NUM_CHANNELS(4),
    .RADIO_SPC(2),
    .NUM_GPIO(4),
    .TIMEOUT_W(16)
  ) dut (
    .radio_clk(clk),
    .radio_rst_n(rst_n),
    .tx_data(tx_data),
    .tx_stb(tx_stb),
    .cfg_wr_en(cfg_wr_en),
    .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .gpio_out(gpio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(
    logic en, logic [1:0] mode, logic idle,
    logic [3:0] ch, logic [3:0] sp, logic [4:0] bs, logic [7:0] pl);
    return {pl, 7'b0, en, mode, idle, ch, sp, bs};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cfg_addr  = a;
    cfg_wdata = d;
    cfg_wr_en = 1'b1;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic stb(input logic [3:0] s);
    tx_stb = s;
    tick();
    tx_stb = 4'b0;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp);
    checks++;
    assert (gpio_out === exp) else begin
      errors++;
      $error("FAIL %s: gpio_out=%b expected %b", tag, gpio_out, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    tx_data   = '0;
    tx_stb    = '0;
    cfg_wr_en = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    tick();
    tick();
    chk("reset_hold", 4'b0000);
    rst_n = 1'b1;
    tick();
    chk("reset_release", 4'b0000);

    // level mode, line 0 = ch0 samp0 bit0
    wr(3'd0, mk(1, 2'd0, 0, 4'd0, 4'd0, 5'd0, 8'd0));
    chk("lvl_cfg", 4'b0000);
    tx_data = 256'd1; stb(4'b0001); chk("lvl_1", 4'b0001);
    tx_data = 256'd0; tick(); chk("lvl_hold", 4'b0001);
    stb(4'b0001); chk("lvl_0", 4'b0000);
    tx_data = 256'd1; stb(4'b0001); chk("lvl_1b", 4'b0001);

    // line 1 = ch3 samp1 bit17 -> tx_data[241]
    wr(3'd0, 32'd0);
    wr(3'd1, mk(1, 2'd0, 0, 4'd3, 4'd1, 5'd17, 8'd0));
    chk("sel_cfg", 4'b0000);
    tx_data = '0; tx_data[241] = 1'b1;
    stb(4'b0111); chk("sel_other_ch", 4'b0000);
    stb(4'b1000); chk("sel_ch3_1", 4'b0010);
    tx_data = '0; tx_data[240] = 1'b1;
    stb(4'b1000); chk("sel_ch3_0", 4'b0000);

    // pulse mode, line 2, pulse_len 4
    wr(3'd2, mk(1, 2'd1, 0, 4'd0, 4'd0, 5'd0, 8'd4));
    tx_data = '0; stb(4'b0001); chk("pls_idle", 4'b0000);
    tx_data = 256'd1; stb(4'b0001);
    tx_stb = 4'b0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("pls_single_%0d", k), (k < 5) ? 4'b0100 : 4'b0000);
      tick();
    end
    tx_data = '0; stb(4'b0001); chk("pls_rearm", 4'b0000);
    tx_data = 256'd1; stb(4'b0001); chk("pls_ext_t1", 4'b0100);
    tx_data = '0; stb(4'b0001); chk("pls_ext_t2", 4'b0100);
    tx_data = 256'd1; stb(4'b0001);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("pls_ext_%0d", k), (k < 5) ? 4'b0100 : 4'b0000);
      tick();
    end
    tx_data = '0; stb(4'b0001);

    // toggle mode, line 3 = bit1, idle 1
    wr(3'd3, mk(1, 2'd2, 1, 4'd0, 4'd0, 5'd1, 8'd0));
    chk("tgl_cfg", 4'b1000);
    tx_data = 256'd0; stb(4'b0001); chk("tgl_p0", 4'b1000);
    tx_data = 256'd2; stb(4'b0001); chk("tgl_p1", 4'b0000);
    tx_data = 256'd2; stb(4'b0001); chk("tgl_p2", 4'b0000);
    tx_data = 256'd0; stb(4'b0001); chk("tgl_p3", 4'b0000);
    tx_data = 256'd2; stb(4'b0001); chk("tgl_p4", 4'b1000);

    // timeout 10 on level line 0
    wr(3'd2, 32'd0);
    wr(3'd3, 32'd0);
    chk("to_cleared", 4'b0000);
    wr(3'd4, 32'd10);
    wr(3'd0, mk(1, 2'd0, 0, 4'd0, 4'd0, 5'd0, 8'd0));
    tx_data = 256'd1; stb(4'b0001);
    for (int k = 1; k <= 11; k++) begin
      chk($sformatf("to_t%0d", k), (k <= 10) ? 4'b0001 : 4'b0000);
      tick();
    end
    stb(4'b0001); chk("to_resume", 4'b0001);
    wr(3'd4, 32'd0);

    // chan_sel 15 holds idle
    wr(3'd2, mk(1, 2'd0, 1, 4'd15, 4'd0, 5'd0, 8'd0));
    chk("oob_cfg", 4'b0101);
    tx_data = '0; stb(4'b1111); chk("oob_0", 4'b0100);
    tx_data = '1; stb(4'b1111); chk("oob_1", 4'b0111);

    // write and strobe on same cycle: write wins
    cfg_addr  = 3'd0;
    cfg_wdata = mk(1, 2'd0, 0, 4'd0, 4'd0, 5'd0, 8'd0);
    cfg_wr_en = 1'b1;
    tx_stb    = 4'b0001;
    tick();
    cfg_wr_en = 1'b0;
    tx_stb    = 4'b0;
    chk("wr_wins", 4'b0110);
    stb(4'b0001); chk("wr_after", 4'b0111);

    // async reset mid-pulse
    wr(3'd2, mk(1, 2'd1, 0, 4'd0, 4'd0, 5'd0, 8'd20));
    chk("rst_cfg", 4'b0011);
    tx_data = '0; stb(4'b0001); chk("rst_arm", 4'b0010);
    tx_data = '1; stb(4'b0001); chk("rst_pulse", 4'b0111);
    tick(); chk("rst_pulse2", 4'b0111);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    stb(4'b1111); chk("rst_post_a", 4'b0000);
    tick(); chk("rst_post_b", 4'b0000);
    wr(3'd0, mk(1, 2'd0, 0, 4'd0, 4'd0, 5'd0, 8'd0));
    stb(4'b0001); chk("rst_reconf", 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
